// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the fetch (IF) and
//            load/store (LS) paths. Grants one requester at a time, runs a
//            fixed-latency access and returns data with a one-cycle valid.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned WAIT_CYC = 2,   // mem_en cycles per access, 1..15
  parameter int unsigned STARVE_N = 2    // LS wins in a row before IF is forced, 1..7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYC - 1);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_N);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;     // 1 = LS owns the current access
  logic [AW-1:0] addr_q,  addr_d;
  logic          we_q,    we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    wait_q,  wait_d;
  logic [2:0]    starve_q, starve_d;

  logic          if_win;
  logic          ls_win;

  // Arbitration: grants are combinational from the requests, IDLE only.
  // rst_n gates them so every output is low while reset is held.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (if_req && (!ls_req || (starve_q == STARVE_MAX))) begin
        if_win = 1'b1;
      end else if (ls_req) begin
        ls_win = 1'b1;
      end
    end
  end

  // Next-state logic: latch the winner's request, count down the access,
  // capture read data on the final mem_en cycle, then pulse valid.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (if_win || ls_win) begin
          owner_d = ls_win;
          addr_d  = ls_win ? ls_addr : if_addr;
          we_d    = ls_win & ls_we;
          wdata_d = ls_win ? ls_wdata : '0;
          wait_d  = WAIT_INIT;
          state_d = ACCESS;
          // Count LS wins that kept a waiting fetch out; any other grant resets.
          if (ls_win && if_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : (starve_q + 3'd1);
          end else begin
            starve_d = '0;
          end
        end
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign if_valid  = (state_q == RESP) & ~owner_q;
  assign ls_valid  = (state_q == RESP) &  owner_q;
  assign if_rdata  = rdata_q;
  assign ls_rdata  = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
